// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the ALU command driver.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_NOT = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_EQU = 3'd6;
  localparam logic [2:0] ALU_BLT = 3'd7;

  localparam int FLG_CARRY = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_OVF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } drv_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding {op, b, a}; pointers carry an extra wrap bit for full detection.
module alu_cmd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [2*WIDTH+2:0]   push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [2*WIDTH+2:0]   head
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2*WIDTH + 3;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the combinational ALU: queues commands, drives registered operands, returns results in order.
// Optional self-check model is built when ALU_CMD_DRIVER_CHECK_EN is defined.
import alu_pkg::*;

module alu_cmd_driver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [2:0]       rsp_op,
  output logic             busy,
  output logic             chk_err,
  output logic [7:0]       chk_err_cnt
);

  drv_state_t         state, state_next;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH+2:0] fifo_head;
  logic               load_alu;
  logic               capture;
  logic               clear_rsp;

  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  alu_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_op, cmd_b, cmd_a}),
    .pop       (capture),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_alu   = 1'b0;
    capture    = 1'b0;
    clear_rsp  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_alu   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        capture    = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          clear_rsp = 1'b1;
          if (!fifo_empty) begin
            load_alu   = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ALU operands are held between loads so the external ALU output stays settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_op     <= '0;
    end else begin
      if (load_alu) begin
        alu_a  <= fifo_head[WIDTH-1:0];
        alu_b  <= fifo_head[2*WIDTH-1:WIDTH];
        alu_op <= fifo_head[2*WIDTH+2:2*WIDTH];
      end
      if (capture) begin
        rsp_result           <= alu_result;
        rsp_flags[FLG_CARRY] <= alu_carry;
        rsp_flags[FLG_ZERO]  <= alu_zero;
        rsp_flags[FLG_OVF]   <= alu_overflow;
        rsp_op               <= alu_op;
        rsp_valid            <= 1'b1;
      end else if (clear_rsp) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_CMD_DRIVER_CHECK_EN
  logic [WIDTH-1:0] ref_bx;
  logic [WIDTH:0]   ref_sum;
  logic [WIDTH-1:0] ref_result;
  logic             ref_ovf;
  logic             mismatch;

  // Carry and overflow are only meaningful for the arithmetic ops (add, sub, blt).
  always_comb begin
    ref_bx  = alu_b ^ {WIDTH{alu_op[0]}};
    ref_sum = {1'b0, alu_a} + {1'b0, ref_bx} + {{WIDTH{1'b0}}, alu_op[0]};
    ref_ovf = (alu_a[WIDTH-1] == ref_bx[WIDTH-1]) && (ref_sum[WIDTH-1] != alu_a[WIDTH-1]);
    case (alu_op)
      ALU_ADD, ALU_SUB: ref_result = ref_sum[WIDTH-1:0];
      ALU_NOT:          ref_result = ~alu_a;
      ALU_AND:          ref_result = alu_a & alu_b;
      ALU_OR:           ref_result = alu_a | alu_b;
      ALU_XOR:          ref_result = alu_a ^ alu_b;
      ALU_EQU:          ref_result = {{(WIDTH-1){1'b0}}, (alu_a == alu_b)};
      ALU_BLT:          ref_result = {{(WIDTH-1){1'b0}}, ref_sum[WIDTH-1] ^ ref_ovf};
      default:          ref_result = '0;
    endcase
    mismatch = (ref_result != alu_result) || ((ref_result == '0) != alu_zero);
    if (alu_op == ALU_ADD || alu_op == ALU_SUB || alu_op == ALU_BLT)
      mismatch = mismatch || (ref_sum[WIDTH] != alu_carry) || (ref_ovf != alu_overflow);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err     <= 1'b0;
      chk_err_cnt <= '0;
    end else if (capture && mismatch) begin
      chk_err <= 1'b1;
      if (chk_err_cnt != 8'hFF)
        chk_err_cnt <= chk_err_cnt + 8'd1;
    end
  end
`else
  assign chk_err     = 1'b0;
  assign chk_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: behavioural ALU, vector table, scoreboard and corner-case sequences.
module tb_alu_cmd_driver;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic [2:0] flg;
  } vec_t;

  typedef struct packed {
    logic [3:0] res;
    logic [2:0] flg;
    logic [2:0] op;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic [2:0] rsp_flags;
  logic [2:0] rsp_op;
  logic       busy;
  logic       chk_err;
  logic [7:0] chk_err_cnt;

  int   compared;
  int   mismatched;
  int   rsp_count;
  int   cyc;
  int   last_rsp_cyc;
  logic check_spacing;
  logic force_bad;
  logic [3:0] cur_res;
  logic [2:0] cur_flg;
  exp_t sb_q[$];
  exp_t sb_e;
  vec_t vecs[13];

  alu_cmd_driver #(.WIDTH(4), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_op       (rsp_op),
    .busy         (busy),
    .chk_err      (chk_err),
    .chk_err_cnt  (chk_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural combinational ALU; force_bad corrupts the result to provoke the checker.
  logic [3:0] m_bx;
  logic [4:0] m_sum;
  logic [3:0] m_r;
  logic       m_ovf;
  always_comb begin
    m_bx  = alu_b ^ {4{alu_op[0]}};
    m_sum = {1'b0, alu_a} + {1'b0, m_bx} + {4'b0, alu_op[0]};
    m_ovf = (alu_a[3] == m_bx[3]) && (m_sum[3] != alu_a[3]);
    case (alu_op)
      3'd0, 3'd1: m_r = m_sum[3:0];
      3'd2:       m_r = ~alu_a;
      3'd3:       m_r = alu_a & alu_b;
      3'd4:       m_r = alu_a | alu_b;
      3'd5:       m_r = alu_a ^ alu_b;
      3'd6:       m_r = {3'b0, alu_a == alu_b};
      default:    m_r = {3'b0, m_sum[3] ^ m_ovf};
    endcase
    if (force_bad)
      m_r = 4'hF;
    alu_result   = m_r;
    alu_zero     = (m_r == 4'h0);
    alu_carry    = (alu_op == 3'd0 || alu_op == 3'd1 || alu_op == 3'd7) ? m_sum[4] : 1'b0;
    alu_overflow = (alu_op == 3'd0 || alu_op == 3'd1 || alu_op == 3'd7) ? m_ovf : 1'b0;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on accepted command, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready)
        sb_q.push_back('{res: cur_res, flg: cur_flg, op: cmd_op});
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          check_output("rsp_result", {28'b0, rsp_result}, {28'b0, sb_e.res});
          check_output("rsp_flags", {29'b0, rsp_flags}, {29'b0, sb_e.flg});
          check_output("rsp_op", {29'b0, rsp_op}, {29'b0, sb_e.op});
        end
        if (check_spacing && last_rsp_cyc >= 0)
          check_output("rsp_spacing", cyc - last_rsp_cyc, 32'd2);
        last_rsp_cyc = cyc;
        rsp_count++;
      end
    end
  end

  task automatic set_cmd(input vec_t v);
    cmd_a     = v.a;
    cmd_b     = v.b;
    cmd_op    = v.op;
    cur_res   = v.res;
    cur_flg   = v.flg;
    cmd_valid = 1'b1;
  endtask

  // Present one command and hold it until accepted; returns just after the accepting edge.
  task automatic apply_stimulus(input vec_t v);
    int n;
    set_cmd(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    if (!cmd_ready)
      check_output("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", {31'b0, (sb_q.size() == 0) && !busy}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    int   start_cnt;
    vec_t bad;

    vecs[0]  = '{4'h7, 4'h1, 3'd0, 4'h8, 3'b100};
    vecs[1]  = '{4'h3, 4'h3, 3'd1, 4'h0, 3'b011};
    vecs[2]  = '{4'hD, 4'h2, 3'd7, 4'h1, 3'b001};
    vecs[3]  = '{4'h5, 4'h5, 3'd6, 4'h1, 3'b000};
    vecs[4]  = '{4'hA, 4'h0, 3'd2, 4'h5, 3'b000};
    vecs[5]  = '{4'hC, 4'hA, 3'd3, 4'h8, 3'b000};
    vecs[6]  = '{4'hC, 4'h3, 3'd4, 4'hF, 3'b000};
    vecs[7]  = '{4'h6, 4'h6, 3'd5, 4'h0, 3'b010};
    vecs[8]  = '{4'hF, 4'h1, 3'd0, 4'h0, 3'b011};
    vecs[9]  = '{4'h8, 4'h1, 3'd1, 4'h7, 3'b101};
    vecs[10] = '{4'h2, 4'hD, 3'd7, 4'h0, 3'b010};
    vecs[11] = '{4'h5, 4'h4, 3'd6, 4'h0, 3'b010};
    vecs[12] = '{4'h7, 4'h8, 3'd7, 4'h0, 3'b110};

    compared      = 0;
    mismatched    = 0;
    rsp_count     = 0;
    cyc           = 0;
    last_rsp_cyc  = -1;
    check_spacing = 1'b0;
    force_bad     = 1'b0;
    cur_res       = '0;
    cur_flg       = '0;
    rst_n         = 1'b1;
    cmd_valid     = 1'b0;
    cmd_a         = '0;
    cmd_b         = '0;
    cmd_op        = '0;
    rsp_ready     = 1'b0;

    // Asynchronous reset asserted mid-cycle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_outputs_zero",
                 {alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_flags, rsp_op, busy, chk_err, chk_err_cnt},
                 32'd0);
    check_output("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("post_reset_busy", {31'b0, busy}, 32'd0);
    check_output("post_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Single add from idle: response must appear in cycle 3.
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(vecs[0]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check_output("latency_cycles", n, 32'd3);
    wait_drain();

    // Table of vectors streamed with rsp_ready high.
    for (int i = 0; i < 13; i++)
      apply_stimulus(vecs[i]);
    wait_drain();

    // Backpressure: DEPTH queued plus one held in the response registers.
    rsp_ready = 1'b0;
    start_cnt = rsp_count;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      set_cmd(vecs[i]);
      @(negedge clk);
      check_output("bp_cmd_ready", {31'b0, cmd_ready}, (i < 5) ? 32'd1 : 32'd0);
      if (i < 5) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(negedge clk);
    check_output("bp_full_hold", {31'b0, cmd_ready}, 32'd0);
    check_output("bp_rsp_held_valid", {31'b0, rsp_valid}, 32'd1);
    check_output("bp_rsp_held_result", {28'b0, rsp_result}, 32'h8);
    @(posedge clk);
    #1;
    last_rsp_cyc  = -1;
    check_spacing = 1'b1;
    rsp_ready     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 30);
    check_output("bp_sixth_accepted", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_drain();
    check_spacing = 1'b0;
    check_output("bp_rsp_count", rsp_count - start_cnt, 32'd6);

    // Corrupted ALU result exercises the optional checker.
    bad = '{4'h1, 4'h1, 3'd0, 4'hF, 3'b000};
    force_bad = 1'b1;
    apply_stimulus(bad);
    wait_drain();
    force_bad = 1'b0;
`ifdef ALU_CMD_DRIVER_CHECK_EN
    check_output("chk_err", {31'b0, chk_err}, 32'd1);
    check_output("chk_err_cnt", {24'b0, chk_err_cnt}, 32'd1);
`else
    check_output("chk_err", {31'b0, chk_err}, 32'd0);
    check_output("chk_err_cnt", {24'b0, chk_err_cnt}, 32'd0);
`endif

    // Reset while the first of three queued commands is in ISSUE.
    @(posedge clk);
    #1;
    set_cmd(vecs[1]);
    @(posedge clk);
    #1 set_cmd(vecs[2]);
    @(posedge clk);
    #1 set_cmd(vecs[3]);
    @(negedge clk);
    #2 rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check_output("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_output("midreset_busy", {31'b0, busy}, 32'd0);
    sb_q.delete();
    start_cnt = rsp_count;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_output("midreset_no_rsp", rsp_count - start_cnt, 32'd0);
    check_output("midreset_idle", {31'b0, busy}, 32'd0);
    check_output("midreset_chk_cleared", {23'b0, chk_err, chk_err_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
